// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NUM_REQ byte producers.
// Grants bounded bursts, gates acceptance on CTS#, and forwards bytes through a one-entry register.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         cts_n,
    output logic                         tx_valid,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BurstMax  = BW'(MAX_BURST);
    localparam logic [GW-1:0] LastReset = GW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    int unsigned          cand;

    // Scan from farthest to nearest so the nearest valid index after last_grant wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_grant_q;
        cand       = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = (32'(last_grant_q) + k) % NUM_REQ;
            if (req_valid[GW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        req_ready    = '0;

        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    burst_cnt_d  = '0;
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (!tx_valid_q && !cts_n && req_valid[grant_q] && (burst_cnt_q < BurstMax)) begin
                    req_ready[grant_q] = 1'b1;
                    tx_data_d          = req_data[32'(grant_q) * DATA_BITS +: DATA_BITS];
                    tx_valid_d         = 1'b1;
                    burst_cnt_d        = burst_cnt_q + BW'(1);
                end
                // Release only looks at the registered output, so a drain costs one extra cycle.
                if (!tx_valid_q && ((burst_cnt_q == BurstMax) || !req_valid[grant_q])) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LastReset;
            burst_cnt_q  <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == StSend);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester queues, expected bytes queued up front,
// a negedge monitor pops and compares every serializer hand-off.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        cts_n = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic [1:0]  grant_id;
    logic        busy;

    uart_tx_arbiter #(
        .NUM_REQ  (4),
        .DATA_BITS(8),
        .MAX_BURST(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .cts_n    (cts_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int drain_cyc = 0;
    logic [7:0] src [4][$];
    logic [9:0] exp_q [$];
    logic [3:0] acc_s = '0;
    logic [3:0] allowed;
    logic [9:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: legality of req_ready every cycle, and byte/grant check on each hand-off.
    always @(negedge clk) begin
        acc_s = resetn ? (req_valid & req_ready) : 4'b0;
        if (resetn) begin
            allowed = (busy && !cts_n && !tx_valid) ? (req_valid & (4'b0001 << grant_id)) : 4'b0;
            chk("req_ready_legal", 32'(req_ready & ~allowed), 32'h0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got grant %0d data %0h want none", grant_id,
                             tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'({grant_id, tx_data}), 32'(e));
                end
                drain_cyc = cyc + 1;
            end
        end
    end

    // Requester models: present queue heads, pop on accepted handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc_s[i] && src[i].size() > 0) void'(src[i].pop_front());
            req_valid[i] = (src[i].size() > 0);
            req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid || busy) && n < 300) begin
            step(1);
            n++;
        end
        chk({name, "_drain_in_time"}, 32'(n < 300), 32'h1);
    endtask

    task automatic wait_pending(input string name, input logic [7:0] want);
        int n = 0;
        while (!(tx_valid && tx_data == want) && n < 60) begin
            step(1);
            n++;
        end
        chk({name, "_pending_in_time"}, 32'(n < 60), 32'h1);
    endtask

    task automatic push(input int g, input logic [7:0] d);
        src[g].push_back(d);
    endtask

    task automatic expect_byte(input logic [1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    initial begin
        int n;
        int g;
        int grants[5];
        int offs[5];
        grants = '{0, 1, 2, 3, 0};
        offs   = '{0, 0, 0, 0, 4};

        // Reset values
        step(2);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        resetn = 1'b1;
        step(1);

        // Full contention: req0 has 8 bytes, others 4; grants 0,1,2,3,0 with 4 bytes each
        for (int k = 0; k < 8; k++) push(0, 8'(k));
        for (int i = 1; i < 4; i++) for (int k = 0; k < 4; k++) push(i, 8'(i * 16 + k));
        for (int j = 0; j < 5; j++)
            for (int k = 0; k < 4; k++) expect_byte(2'(grants[j]), 8'(grants[j] * 16 + offs[j] + k));
        wait_drain("contention");

        // Single requester 1
        push(1, 8'h41); push(1, 8'h42); push(1, 8'h43);
        expect_byte(2'd1, 8'h41); expect_byte(2'd1, 8'h42); expect_byte(2'd1, 8'h43);
        wait_drain("single");
        chk("single_busy_low", 32'(busy), 32'h0);
        chk("single_grant_kept", 32'(grant_id), 32'h1);

        // CTS# pause with byte 2 pending
        for (int k = 1; k <= 4; k++) begin
            push(1, 8'(8'h50 + k));
            expect_byte(2'd1, 8'(8'h50 + k));
        end
        wait_pending("cts", 8'h52);
        cts_n = 1'b1;
        tx_ready = 1'b0;
        step(3);
        chk("cts_pending_valid", 32'(tx_valid), 32'h1);
        chk("cts_pending_data", 32'(tx_data), 32'h52);
        tx_ready = 1'b1;
        step(4);
        chk("cts_no_accept", 32'(tx_valid), 32'h0);
        chk("cts_grant_held", 32'(busy), 32'h1);
        cts_n = 1'b0;
        wait_drain("cts");

        // Serializer stall for 10 cycles
        push(0, 8'h61); push(0, 8'h62);
        expect_byte(2'd0, 8'h61); expect_byte(2'd0, 8'h62);
        tx_ready = 1'b0;
        wait_pending("stall", 8'h61);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("stall_valid", 32'(tx_valid), 32'h1);
            chk("stall_data", 32'(tx_data), 32'h61);
        end
        tx_ready = 1'b1;
        wait_drain("stall");

        // Early release: req2 sends 2 bytes, req3 then gets a fresh 4-byte burst
        push(2, 8'h71); push(2, 8'h72);
        for (int k = 1; k <= 4; k++) push(3, 8'(8'h80 + k));
        expect_byte(2'd2, 8'h71); expect_byte(2'd2, 8'h72);
        for (int k = 1; k <= 4; k++) expect_byte(2'd3, 8'(8'h80 + k));
        n = 0;
        g = 0;
        while (n < 60) begin
            @(negedge clk);
            if (busy && grant_id == 2'd3) begin
                g = 1;
                break;
            end
            n++;
        end
        chk("early_grant3_seen", 32'(g), 32'h1);
        chk("early_grant_gap", 32'(cyc - drain_cyc), 32'h2);
        wait_drain("early");

        // Reset mid-burst with a byte pending
        for (int k = 1; k <= 4; k++) push(2, 8'(8'h90 + k));
        tx_ready = 1'b0;
        wait_pending("rstmid", 8'h91);
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) src[i].delete();
        step(1);
        chk("rstmid_tx_valid", 32'(tx_valid), 32'h0);
        chk("rstmid_tx_data", 32'(tx_data), 32'h0);
        chk("rstmid_req_ready", 32'(req_ready), 32'h0);
        chk("rstmid_grant_id", 32'(grant_id), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            push(i, 8'(8'hA0 + i));
            expect_byte(2'(i), 8'(8'hA0 + i));
        end
        tx_ready = 1'b1;
        step(1);
        resetn = 1'b1;
        wait_drain("rstmid");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
